rv32_mod_muldiv: RTL and testbench
==================================

RV32_MOD_MULDIV -- requirements
Module: rv32_mod_muldiv

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, listed first: clk input 1 (rising-edge clock); rst input 1 (synchronous, active-high reset).
REQ-002 The block SHALL provide the port func, input, 5 bits: bits [2:0] are the M-extension funct3; bits [4:3] are ignored.
REQ-003 The block SHALL provide read0_data, input, 32 bits: operand rs1 (multiplicand or dividend).
REQ-004 The block SHALL provide read1_data, input, 32 bits: operand rs2 (multiplier or divisor).
REQ-005 The block SHALL provide req_valid, input, 1 bit: the issuer presents an operation.
REQ-006 The block SHALL provide req_ready, output, 1 bit: the unit can accept an operation.
REQ-007 The block SHALL provide kill, input, 1 bit: synchronous abort of the in-flight operation (pipeline flush).
REQ-008 The block SHALL provide resp_valid, output, 1 bit: result is valid.
REQ-009 The block SHALL provide resp_ready, input, 1 bit: the consumer takes the result.
REQ-010 The block SHALL provide result, output, 32 bits: the operation result.
REQ-011 The block SHALL provide busy, output, 1 bit: high in every state except IDLE.

Function
REQ-012 The block SHALL decode func[2:0] as: 000 MUL (low 32 bits), 001 MULH (signed x signed, high), 010 MULHSU (signed rs1 x unsigned rs2, high), 011 MULHU (high), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-013 The block SHALL use the states IDLE, PREP, CALC, FIX and DONE.
REQ-014 req_ready SHALL be high only in IDLE; an accept SHALL occur on an edge with req_valid and req_ready both high; IDLE SHALL then go to PREP.
REQ-015 The block SHALL capture func and both operands at the accept edge; input changes after acceptance SHALL have no effect.
REQ-016 PREP (1 cycle) SHALL take absolute values for the signed variants, record the result sign, and load the 6-bit iteration counter with 0.
REQ-017 CALC SHALL run for exactly 32 cycles, using radix-2 shift-add for multiply and restoring shift-subtract for divide, with one bit per cycle.
REQ-018 After counter value 31, CALC SHALL go to FIX.
REQ-019 FIX (1 cycle) SHALL apply two's-complement negation where the sign requires it and select the upper or lower product half, or the quotient or remainder.
REQ-020 FIX SHALL go to DONE and register result.
REQ-021 For a normal operation, resp_valid SHALL rise on the 34th rising edge after the accept edge.
REQ-022 For a division by zero, PREP SHALL go directly to DONE, giving resp_valid on the 1st edge after accept.
- DIV and DIVU SHALL return 0xFFFFFFFF.
- REM and REMU SHALL return the dividend unchanged.
REQ-023 For signed overflow (DIV or REM with 0x80000000 / 0xFFFFFFFF), PREP SHALL go directly to DONE.
- DIV SHALL return 0x80000000.
- REM SHALL return 0x00000000.
REQ-024 Remainder sign SHALL follow the dividend, and quotient sign SHALL be the XOR of the operand signs (RISC-V truncating semantics).
REQ-025 In DONE, resp_valid and result SHALL hold stable until resp_ready is high, and that edge SHALL go to IDLE.
- req_ready SHALL rise in the following cycle, so there is no same-cycle re-accept.
REQ-026 kill high on any edge SHALL force IDLE, drop resp_valid and discard the operation.
- kill in IDLE SHALL be a no-op, and an accept in that same cycle SHALL be ignored.
REQ-027 result SHALL hold its last value outside DONE; only resp_valid qualifies it.

Reset
REQ-028 When rst is high on a rising edge, the block SHALL enter IDLE with:
- req_ready = 1, resp_valid = 0, busy = 0, result = 0x00000000;
- counter and working registers = 0.
REQ-029 Reset SHALL take priority over kill, kill SHALL take priority over handshakes, and reset mid-operation SHALL abort without producing a response.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- MUL 0x00000007 x 0xFFFFFFFD -> result 0xFFFFFFEB; resp_valid rises 34 edges after accept; busy high throughout.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9 / 0x00000002 -> 0xFFFFFFFD; REM of the same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
- DIVU 5 / 0 -> 0xFFFFFFFF and REMU 5 / 0 -> 5, with resp_valid on the 1st edge after accept; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM of the same operands -> 0.
- resp_ready held low for 10 cycles in DONE -> result and resp_valid stable throughout; operand inputs toggled during CALC -> result unchanged.
- kill asserted during CALC cycle 15 -> IDLE on the next cycle, resp_valid never rises; rst asserted during FIX -> every output at its reset value, and a new MUL 3 x 4 afterwards returns 12.

Source files
------------

// File: rtl/rv32_mod_muldiv.sv
// Iterative RV32 M-extension unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle, with valid/ready handshakes on both request and response.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// PREP  | take absolute values, record result sign, catch divide special cases
// CALC  | 32 iterations of shift-add or shift-subtract
// FIX   | apply sign and select product half / quotient / remainder
// DONE  | result presented until resp_ready
module rv32_mod_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  func,
  input  logic [31:0] read0_data,
  input  logic [31:0] read1_data,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        kill,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] result,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  func_q, func_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [63:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;
  logic [31:0] result_q, result_d;

  logic        unused_func;
  logic        is_div, sign_a, sign_b, neg_a, neg_b, div_zero, div_ovf;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum, div_shift;
  logic [31:0] div_diff;
  logic        div_ge;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign unused_func = ^func[4:3];

  assign is_div   = func_q[2];
  assign sign_a   = (func_q == 3'b001) || (func_q == 3'b010) || (func_q == 3'b100) || (func_q == 3'b110);
  assign sign_b   = (func_q == 3'b001) || (func_q == 3'b100) || (func_q == 3'b110);
  assign neg_a    = sign_a & opa_q[31];
  assign neg_b    = sign_b & opb_q[31];
  assign abs_a    = neg_a ? (32'd0 - opa_q) : opa_q;
  assign abs_b    = neg_b ? (32'd0 - opb_q) : opb_q;
  assign div_zero = is_div && (opb_q == 32'd0);
  assign div_ovf  = is_div && !func_q[0] && (opa_q == 32'h8000_0000) && (opb_q == 32'hFFFF_FFFF);

  // During CALC opa_q holds the multiplicand or divisor; acc_q holds {high, low} work halves.
  assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opa_q} : 33'd0);
  assign div_shift = {acc_q[63:32], acc_q[31]};
  assign div_ge    = div_shift >= {1'b0, opa_q};
  assign div_diff  = div_shift[31:0] - opa_q;

  assign prod_fix = neg_q ? (64'd0 - acc_q) : acc_q;
  assign quo_fix  = neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
  assign rem_fix  = neg_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

  always_comb begin
    state_d  = state_q;
    func_d   = func_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    result_d = result_q;
    if (kill) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            func_d  = func[2:0];
            opa_d   = read0_data;
            opb_d   = read1_data;
            state_d = PREP;
          end
        end
        PREP: begin
          cnt_d = 6'd0;
          if (div_zero) begin
            result_d = func_q[1] ? opa_q : 32'hFFFF_FFFF;
            state_d  = DONE;
          end else if (div_ovf) begin
            result_d = func_q[1] ? 32'h0000_0000 : 32'h8000_0000;
            state_d  = DONE;
          end else begin
            opa_d   = is_div ? abs_b : abs_a;
            acc_d   = {32'd0, is_div ? abs_a : abs_b};
            neg_d   = (is_div && func_q[1]) ? neg_a : (neg_a ^ neg_b);
            state_d = CALC;
          end
        end
        CALC: begin
          if (is_div) begin
            acc_d = div_ge ? {div_diff, acc_q[30:0], 1'b1}
                           : {div_shift[31:0], acc_q[30:0], 1'b0};
          end else begin
            acc_d = {mul_sum, acc_q[31:1]};
          end
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_d = FIX;
        end
        FIX: begin
          case (func_q)
            3'b000:         result_d = prod_fix[31:0];
            3'b100, 3'b101: result_d = quo_fix;
            3'b110, 3'b111: result_d = rem_fix;
            default:        result_d = prod_fix[63:32];
          endcase
          state_d = DONE;
        end
        DONE: begin
          if (resp_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      func_q   <= 3'd0;
      opa_q    <= 32'd0;
      opb_q    <= 32'd0;
      acc_q    <= 64'd0;
      cnt_q    <= 6'd0;
      neg_q    <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      func_q   <= func_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign result     = result_q;

endmodule

// File: tb/tb_rv32_mod_muldiv.sv
// Self-checking bench for rv32_mod_muldiv: directed vector table, multi-cycle
// corner sequences (stall, kill, reset mid-op) and random ops against a 64-bit model.
module tb_rv32_mod_muldiv;

  logic        clk = 1'b0;
  logic        rst, req_valid, kill, resp_ready;
  logic [4:0]  func;
  logic [31:0] read0_data, read1_data;
  logic        req_ready, resp_valid, busy;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rv32_mod_muldiv dut (
    .clk        (clk),
    .rst        (rst),
    .func       (func),
    .read0_data (read0_data),
    .read1_data (read1_data),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .kill       (kill),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .result     (result),
    .busy       (busy)
  );

  typedef struct {
    string       name;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic with the RISC-V special cases.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = 64'd0;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 32'd0)) return 1;
    if (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op from IDLE; inputs are scrambled every cycle after the accept edge.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int hold,
                       output logic [31:0] res, output int lat, output bit busy_ok, output bit stable_ok);
    func       = {2'($urandom_range(0, 3)), f};
    read0_data = a;
    read1_data = b;
    req_valid  = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat       = 0;
    busy_ok   = 1'b1;
    stable_ok = 1'b1;
    while (!resp_valid && lat < 100) begin
      read0_data = $urandom;
      read1_data = $urandom;
      func       = 5'($urandom);
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!resp_valid || result !== res || !busy) stable_ok = 1'b0;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    vec_t        vecs[$];
    logic [31:0] res, exp_r;
    int          lat;
    bit          busy_ok, stable_ok, seen;
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    vecs.push_back('{"mul",       3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34});
    vecs.push_back('{"mulh",      3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34});
    vecs.push_back('{"mulhsu",    3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34});
    vecs.push_back('{"mulhu",     3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34});
    vecs.push_back('{"div",       3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34});
    vecs.push_back('{"rem",       3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34});
    vecs.push_back('{"divu",      3'd5, 32'd100,       32'd7,         32'd14,        34});
    vecs.push_back('{"remu",      3'd7, 32'd100,       32'd7,         32'd2,         34});
    vecs.push_back('{"divu_zero", 3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{"remu_zero", 3'd7, 32'd5,         32'd0,         32'd5,         1});
    vecs.push_back('{"div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
    vecs.push_back('{"rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1});

    rst = 1'b1; req_valid = 1'b0; kill = 1'b0; resp_ready = 1'b0;
    func = 5'd0; read0_data = 32'd0; read1_data = 32'd0;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    chk("reset req_ready",  32'(req_ready),  32'd1);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset busy",       32'(busy),       32'd0);
    chk("reset result",     result,          32'd0);

    foreach (vecs[i]) begin
      do_op(vecs[i].f, vecs[i].a, vecs[i].b, 0, res, lat, busy_ok, stable_ok);
      chk({vecs[i].name, " result"},  res,         vecs[i].exp);
      chk({vecs[i].name, " latency"}, 32'(lat),    32'(vecs[i].lat));
      chk({vecs[i].name, " busy"},    32'(busy_ok), 32'd1);
      chk({vecs[i].name, " ready after"}, 32'(req_ready), 32'd1);
    end

    // Consumer stalls 10 cycles in DONE.
    do_op(3'd5, 32'd100, 32'd7, 10, res, lat, busy_ok, stable_ok);
    chk("stall result", res, 32'd14);
    chk("stall stable", 32'(stable_ok), 32'd1);

    // kill during CALC cycle 15.
    func = 5'd0; read0_data = 32'd5; read1_data = 32'd6; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill req_ready",  32'(req_ready),  32'd1);
    chk("kill busy",       32'(busy),       32'd0);
    chk("kill resp_valid", 32'(resp_valid), 32'd0);
    chk("kill result held", result, 32'd14);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (resp_valid) seen = 1'b1;
    end
    chk("kill no resp", 32'(seen), 32'd0);

    // kill in IDLE blocks a simultaneous accept.
    kill = 1'b1; req_valid = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0; req_valid = 1'b0;
    chk("kill idle busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("kill idle busy2", 32'(busy), 32'd0);

    // reset while in FIX.
    func = 5'd0; read0_data = 32'h1234; read1_data = 32'h10; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (33) @(posedge clk);
    #1;
    chk("fix busy", 32'(busy), 32'd1);
    chk("fix no resp", 32'(resp_valid), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst req_ready",  32'(req_ready),  32'd1);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst busy",       32'(busy),       32'd0);
    chk("rst result",     result,          32'd0);
    do_op(3'd0, 32'd3, 32'd4, 0, res, lat, busy_ok, stable_ok);
    chk("post rst mul", res, 32'd12);
    chk("post rst lat", 32'(lat), 32'd34);

    for (int i = 0; i < 150; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      exp_r = ref_model(rf, ra, rb);
      do_op(rf, ra, rb, 0, res, lat, busy_ok, stable_ok);
      chk($sformatf("rand f%0d %h %h result", rf, ra, rb), res, exp_r);
      chk($sformatf("rand f%0d %h %h latency", rf, ra, rb), 32'(lat), 32'(ref_lat(rf, ra, rb)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
